// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its ROM, shared RAM port and ALU.
// Latency: wires only; no state of its own.
// Backpressure: ram_gnt is the only flow-control signal; the sequencer holds its RAM request until the grant arrives.
// Ports (master = sequencer side):
//   out: rom_address, rom_read_enable, ram_addr, ram_read, ram_write, ram_data_out, alu_op, alu_a, alu_b
//   in : rom_data, ram_gnt, ram_data_in, result
interface instr_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic [PC_W-1:0]   rom_address;
  logic              rom_read_enable;
  logic [DATA_W-1:0] rom_data;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_read;
  logic              ram_write;
  logic              ram_gnt;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;

  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] result;

  modport master (
    output rom_address, rom_read_enable, ram_addr, ram_read, ram_write,
           ram_data_out, alu_op, alu_a, alu_b,
    input  rom_data, ram_gnt, ram_data_in, result
  );

  modport slave (
    input  rom_address, rom_read_enable, ram_addr, ram_read, ram_write,
           ram_data_out, alu_op, alu_a, alu_b,
    output rom_data, ram_gnt, ram_data_in, result
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/read/exec/write sequencer owning PC, IR and operand registers.
// Latency (ram_gnt=1): NOP/JMP/HALT 2 cycles, JZ 4, MOV 5, ALU 6; each ungranted RAM cycle adds 1.
// Backpressure: READ_A, READ_B and WRITE hold with stable requests until ram_gnt is seen.
// Ports: clk, reset (async active-low); bus (instr_sequencer_if.master: ROM, RAM, ALU);
//        pc, cu_state, halted, retired (status).
module instr_sequencer #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_sequencer_if.master   bus,
  output logic [PC_W-1:0]     pc,
  output logic [2:0]          cu_state,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ_A = 3'd3,
    S_READ_B = 3'd4,
    S_EXEC   = 3'd5,
    S_WRITE  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       retired_q, retired_d;
  logic              retire;

  // Request/ALU outputs are registered; their _d values are decoded from the
  // next state so each output is valid for the whole cycle of its state.
  logic              rom_re_q, rom_re_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              halted_q, halted_d;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] dest_q;
  logic [3:0]        op_rom;

  assign op_q   = ir_q[DATA_W-1 -: 4];
  assign dest_q = ir_q[2*ADDR_W-1 : ADDR_W];
  assign op_rom = bus.rom_data[DATA_W-1 -: 4];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    retire  = 1'b0;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = bus.rom_data;
        pc_d = pc_q + PC_W'(1);
        case (op_rom)
          OP_NOP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          // MOV and JZ only need the src operand, so they skip READ_A.
          OP_MOV, OP_JZ: state_d = S_READ_B;
          OP_JMP: begin
            pc_d    = bus.rom_data[PC_W-1:0];
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: state_d = S_READ_A;
        endcase
      end
      S_READ_A: begin
        if (bus.ram_gnt) state_d = S_READ_B;
      end
      S_READ_B: begin
        // ram_data_in here is the result of the granted READ_A (dest value).
        if (bus.ram_gnt) begin
          a_d     = bus.ram_data_in;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        b_d = bus.ram_data_in;
        if (op_q == OP_JZ) begin
          if (bus.ram_data_in == '0) pc_d = PC_W'(dest_q);
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.ram_gnt) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    retired_d = retire ? retired_q + 16'd1 : retired_q;

    rom_re_d    = (state_d == S_FETCH);
    ram_read_d  = (state_d == S_READ_A) || (state_d == S_READ_B);
    ram_write_d = (state_d == S_WRITE);
    halted_d    = (state_d == S_HALT);
    case (state_d)
      S_READ_A, S_WRITE: ram_addr_d = ir_d[2*ADDR_W-1 : ADDR_W];
      S_READ_B:          ram_addr_d = ir_d[ADDR_W-1:0];
      default:           ram_addr_d = '0;
    endcase
    alu_op_d = ram_write_d ? ir_d[DATA_W-1 -: 4] : 4'h0;
    alu_a_d  = ram_write_d ? a_d : '0;
    alu_b_d  = ram_write_d ? b_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      retired_q   <= '0;
      rom_re_q    <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      alu_op_q    <= 4'h0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      retired_q   <= retired_d;
      rom_re_q    <= rom_re_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.rom_address     = pc_q;
  assign bus.rom_read_enable = rom_re_q;
  assign bus.ram_addr        = ram_addr_q;
  assign bus.ram_read        = ram_read_q;
  assign bus.ram_write       = ram_write_q;
  assign bus.alu_op          = alu_op_q;
  assign bus.alu_a           = alu_a_q;
  assign bus.alu_b           = alu_b_q;
  // Write data follows the combinational ALU result, so it cannot be registered.
  assign bus.ram_data_out    = !ram_write_q        ? '0  :
                               (op_q == OP_MOV)    ? b_q : bus.result;

  assign pc       = pc_q;
  assign cu_state = state_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with behavioural ROM, granted RAM and ALU models.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic [2:0]  cu_state;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];
  logic [15:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_dat = '0;
  int          wr_count = 0;
  int          w0;

  instr_sequencer_if #(.PC_W(8), .ADDR_W(6), .DATA_W(16)) bus_if ();

  instr_sequencer #(.PC_W(8), .ADDR_W(6), .DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .pc       (pc),
    .cu_state (cu_state),
    .halted   (halted),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Registered ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus_if.rom_read_enable) bus_if.rom_data <= rom[bus_if.rom_address];
  end

  // RAM: granted read data appears next cycle and holds; granted writes commit.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_dat;
    if (bus_if.ram_read && bus_if.ram_gnt) bus_if.ram_data_in <= mem[bus_if.ram_addr];
    if (bus_if.ram_write && bus_if.ram_gnt) begin
      mem[bus_if.ram_addr] <= bus_if.ram_data_out;
      wr_count <= wr_count + 1;
    end
  end

  assign bus_if.result = (bus_if.alu_op == 4'h1) ? bus_if.alu_a + bus_if.alu_b :
                         (bus_if.alu_op == 4'h2) ? bus_if.alu_a - bus_if.alu_b :
                                                   bus_if.alu_a ^ bus_if.alu_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] v);
    pre_addr = a;
    pre_dat  = v;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b0;
    bus_if.ram_gnt = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus_if.ram_gnt = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // ---- reset, first fetch, ALU add, then dest==src add ----
    rom[0] = 16'h1042;
    rom[1] = 16'h1041;
    @(negedge clk);
    preload(6'd1, 16'd5);
    preload(6'd2, 16'd7);
    chk("rst_state", cu_state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_rom_re", bus_if.rom_read_enable, 0);
    chk("rst_rd_wr", {bus_if.ram_read, bus_if.ram_write}, 0);
    chk("rst_alu", {bus_if.alu_op, bus_if.alu_a, bus_if.alu_b}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b1;
    tick(); chk("s1_state", cu_state, 1); chk("s1_rom_re", bus_if.rom_read_enable, 1);
    chk("s1_rom_addr", bus_if.rom_address, 8'h00);
    tick(); chk("s2_state", cu_state, 2); chk("s2_rom_re", bus_if.rom_read_enable, 0);
    tick(); chk("add_ra_state", cu_state, 3); chk("add_ra_addr", bus_if.ram_addr, 1);
    chk("add_ra_read", bus_if.ram_read, 1); chk("pc_after_decode", pc, 8'h01);
    tick(); chk("add_rb_state", cu_state, 4); chk("add_rb_addr", bus_if.ram_addr, 2);
    tick(); chk("add_ex_state", cu_state, 5); chk("add_ex_read", bus_if.ram_read, 0);
    tick(); chk("add_wr_state", cu_state, 6); chk("add_wr_req", {bus_if.ram_read, bus_if.ram_write}, 2'b01);
    chk("add_wr_addr", bus_if.ram_addr, 1); chk("add_alu_a", bus_if.alu_a, 5);
    chk("add_alu_b", bus_if.alu_b, 7); chk("add_alu_op", bus_if.alu_op, 1);
    chk("add_wr_data", bus_if.ram_data_out, 12); chk("add_retired_pre", retired, 0);
    tick(); chk("add_done_state", cu_state, 1); chk("add_retired", retired, 1);
    chk("add_mem1", mem[1], 12); chk("add_next_fetch", bus_if.rom_address, 8'h01);
    tick(); tick(); chk("same_ra_addr", bus_if.ram_addr, 1);
    tick(); chk("same_rb_state", cu_state, 4); chk("same_rb_addr", bus_if.ram_addr, 1);
    tick(); tick(); chk("same_wr_data", bus_if.ram_data_out, 24);
    tick(); chk("same_mem1", mem[1], 24); chk("same_retired", retired, 2);

    // ---- grant stalls: 3 in READ_B, 2 in WRITE, 11 cycles total ----
    enter_reset();
    preload(6'd1, 16'd5);
    preload(6'd2, 16'd7);
    reset = 1'b1;
    tick(); tick(); tick(); tick();
    chk("stall_rb_enter", cu_state, 4);
    bus_if.ram_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rb_state", cu_state, 4);
      chk("stall_rb_req", {bus_if.ram_read, bus_if.ram_write}, 2'b10);
      chk("stall_rb_addr", bus_if.ram_addr, 2);
    end
    bus_if.ram_gnt = 1'b1;
    tick(); chk("stall_ex_state", cu_state, 5);
    tick(); chk("stall_wr_enter", cu_state, 6);
    bus_if.ram_gnt = 1'b0;
    w0 = wr_count;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_wr_state", cu_state, 6);
      chk("stall_wr_req", {bus_if.ram_read, bus_if.ram_write}, 2'b01);
      chk("stall_wr_addr", bus_if.ram_addr, 1);
      chk("stall_wr_data", bus_if.ram_data_out, 12);
      chk("stall_no_write", wr_count, w0);
    end
    bus_if.ram_gnt = 1'b1;
    tick(); chk("stall_done_state", cu_state, 1); chk("stall_mem1", mem[1], 12);
    chk("stall_retired", retired, 1);

    // ---- JZ taken (mem[3]==0) then not taken (mem[3]==1) ----
    for (int k = 0; k < 2; k++) begin
      enter_reset();
      rom[0] = 16'hD004;
      rom[4] = 16'hE283;
      preload(6'd3, 16'(k));
      reset = 1'b1;
      tick(); tick(); tick();
      chk("jz_jmp_fetch", bus_if.rom_address, 8'h04); chk("jz_jmp_retired", retired, 1);
      tick(); tick(); chk("jz_rb_state", cu_state, 4); chk("jz_rb_addr", bus_if.ram_addr, 3);
      tick(); chk("jz_ex_state", cu_state, 5);
      tick(); chk("jz_done_state", cu_state, 1); chk("jz_retired", retired, 2);
      chk("jz_pc", pc, (k == 0) ? 8'h0A : 8'h05);
    end

    // ---- JMP chain into 0xFF NOP and wrap to 0x00 ----
    enter_reset();
    rom[0] = 16'hD010; rom[8'h10] = 16'hD020; rom[8'h20] = 16'hD0FF; rom[8'hFF] = 16'h0000;
    reset = 1'b1;
    tick(); tick(); tick(); chk("jmp_10", bus_if.rom_address, 8'h10);
    tick(); tick(); chk("jmp_20", bus_if.rom_address, 8'h20);
    tick(); tick(); chk("jmp_ff", bus_if.rom_address, 8'hFF);
    tick(); tick(); chk("wrap_fetch", bus_if.rom_address, 8'h00);
    chk("wrap_state", cu_state, 1); chk("wrap_retired", retired, 4);

    // ---- JMP to own address ----
    enter_reset();
    rom[0] = 16'hD000;
    reset = 1'b1;
    tick(); tick(); tick(); chk("self_jmp1", bus_if.rom_address, 8'h00);
    tick(); tick(); chk("self_jmp2", bus_if.rom_address, 8'h00); chk("self_retired", retired, 2);

    // ---- MOV mem[1] <= mem[2] ----
    enter_reset();
    rom[0] = 16'hC042;
    preload(6'd1, 16'd0);
    preload(6'd2, 16'd9);
    reset = 1'b1;
    tick(); tick(); tick(); chk("mov_rb_addr", bus_if.ram_addr, 2); chk("mov_rb_state", cu_state, 4);
    tick(); tick(); chk("mov_wr_addr", bus_if.ram_addr, 1); chk("mov_wr_data", bus_if.ram_data_out, 9);
    tick(); chk("mov_mem1", mem[1], 9); chk("mov_retired", retired, 1);

    // ---- HALT then asynchronous reset ----
    enter_reset();
    rom[0] = 16'hF000;
    reset = 1'b1;
    tick(); tick(); tick();
    chk("halt_state", cu_state, 7); chk("halt_flag", halted, 1); chk("halt_retired", retired, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_no_req", {bus_if.rom_read_enable, bus_if.ram_read, bus_if.ram_write}, 3'b000);
      chk("halt_hold", cu_state, 7);
    end
    #1 reset = 1'b0;
    #1;
    chk("arst_state", cu_state, 0); chk("arst_pc", pc, 0);
    chk("arst_halted", halted, 0); chk("arst_retired", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit CPU datapath.
- Fetches instructions from the 256x16 ROM, decodes them as opcode[15:12], dest[11:6] and src[5:0], and sequences the RAM operand reads, the ALU operation and the RAM writeback.
- Replaces the free-running fetch FSM. It owns the PC, the IR and the operand registers, and honours a RAM grant so the RAM port can be shared.

Parameters:
- PC_W, 8, ROM address / PC width
- ADDR_W, 6, RAM address width (dest/src field width)
- DATA_W, 16, instruction and data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rom_address  out  PC_W  ROM address (= pc)
- rom_read_enable  out  1  ROM read strobe; ROM is registered, so rom_data is valid the next cycle
- rom_data  in  DATA_W  ROM read data
- ram_addr  out  ADDR_W  RAM address for a read or write
- ram_read  out  1  RAM read request
- ram_write  out  1  RAM write request
- ram_gnt  in  1  RAM port granted this cycle
- ram_data_out  out  DATA_W  RAM write data
- ram_data_in  in  DATA_W  RAM read data; 1-cycle latency; holds its value until the next granted read
- alu_op  out  4  ALU operation select
- alu_a, alu_b  out  DATA_W  ALU operands
- result  in  DATA_W  combinational ALU result
- pc  out  PC_W  program counter
- cu_state  out  3  current state encoding
- halted  out  1  high while in HALT
- retired  out  16  count of completed instructions, wraps

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, READ_A=3, READ_B=4, EXEC=5, WRITE=6, HALT=7.
- Reset (asynchronous, active-low):
  - state=IDLE; pc, IR, A, B and retired all 0.
  - All request outputs are 0; alu_op, alu_a and alu_b are 0.
  - Reset mid-instruction aborts it with no RAM write.
- IDLE: go to FETCH on the next clk.
- FETCH:
  - rom_read_enable=1, rom_address=pc.
  - Next state is DECODE.
- DECODE:
  - IR <= rom_data.
  - pc <= pc+1, wrapping 0xFF -> 0x00.
  - Next state is chosen from rom_data[15:12], as listed below.
- Instruction set and next state out of DECODE:
  - 0x0 NOP: go to FETCH, retire.
  - 0x1-0xB ALU: mem[dest] <= mem[dest] op mem[src]; alu_op = opcode. Go to READ_A.
  - 0xC MOV: mem[dest] <= mem[src]. Go to READ_B.
  - 0xD JMP: pc <= IR[7:0], overriding the increment. Go to FETCH, retire.
  - 0xE JZ: if mem[src]==0 then pc <= {2'b00,dest}. Go to READ_B.
  - 0xF HALT: go to HALT, retire.
- READ_A:
  - ram_read=1, ram_addr=dest.
  - Advance to READ_B only in a cycle with ram_gnt=1; otherwise hold.
- READ_B:
  - ram_read=1, ram_addr=src.
  - On the granted edge, A <= ram_data_in (the dest value) and go to EXEC.
  - Otherwise hold.
- EXEC:
  - B <= ram_data_in.
  - For JZ: if ram_data_in==0, pc <= {2'b00,dest}. Then go to FETCH and retire.
  - For other opcodes, go to WRITE.
- WRITE:
  - ram_write=1, ram_addr=dest.
  - ram_data_out = result for ALU ops; ram_data_out = B for MOV.
  - alu_a=A, alu_b=B, alu_op=IR[15:12] (0 otherwise).
  - Hold until ram_gnt=1; then go to FETCH and retire.
- Request and output rules:
  - ram_read and ram_write are never high together; ram_read/ram_write/ram_addr stay stable while stalled.
  - In every state except WRITE, alu_a, alu_b and alu_op are 0.
- HALT:
  - halted=1, with no ROM or RAM requests.
  - Stays in HALT until reset.
- retired increments by 1 on the edge leaving the final state of each instruction; it wraps 0xFFFF -> 0.
- Latency with ram_gnt=1: NOP/JMP/HALT 2 cycles, JZ 4, MOV 5, ALU 6. Each stalled cycle adds 1.
- Boundary cases:
  - An instruction at pc=0xFF fetches the next one from 0x00.
  - dest==src is legal: both reads are issued.
  - JMP to its own address loops forever.

Test Plan:
- Reset and first fetch: hold reset=0 for 3 cycles, then release. Expect cu_state 0 -> 1 -> 2; rom_read_enable=1 only in FETCH with rom_address=0x00; pc=0x01 after DECODE.
- ALU add: ROM[0]=0x1042 (op 1, dest 1, src 2), mem[1]=5, mem[2]=7, ram_gnt=1. Expect reads at addresses 1 then 2; WRITE with alu_a=5, alu_b=7, alu_op=1, ram_addr=1; 6 cycles; retired=1.
- Grant stall: same program with ram_gnt=0 for 3 cycles during READ_B and 2 cycles during WRITE. Expect the state held with stable outputs, the correct value written, and 11 cycles in total.
- JZ: mem[3]=0, ROM[4]=0xE283 (dest 0x0A, src 3). Expect pc=0x0A after EXEC. Repeat with mem[3]=1: expect pc=0x05.
- JMP/wrap: ROM[0xFF]=0x0000 (NOP) with pc=0xFF. Expect the next fetch at 0x00. ROM[0x10]=0xD020: expect the next fetch at 0x20.
- HALT and async reset: ROM[0]=0xF000. Expect halted=1, no requests for 20 cycles. Then assert reset mid-cycle: outputs clear immediately and pc=0.
